usb_fifo_arbiter: RTL

- Sequences the FX2 slave-FIFO bus (usb_slrd/usb_slwr/usb_sloe/usb_addr/8-bit data) and shares it among four endpoint requesters.
  - EP2 (host commands in) and EP4 (host audio in) are read paths.
  - EP6 (audio out) and EP8 (status out) are write paths.
- Round-robin grants, bounded bursts, guaranteed bus turnaround between direction changes.
- Sits between the FX2 pads and the command decoder / audio buffer logic in usb_toplevel; runs on the interface clock.

---
 rtl/usb_fifo_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/usb_fifo_arbiter.sv
// FX2 slave-FIFO bus sequencer: round-robin sharing of the bus among two read endpoints
// (EP2/EP4) and two write endpoints (EP6/EP8), with bounded bursts and a turnaround cycle.
module usb_fifo_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int BURST_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       usb_slrd,
    output logic       usb_slwr,
    output logic       usb_sloe,
    output logic [1:0] usb_addr,
    output logic [7:0] usb_data_in,
    output logic       usb_data_oe,
    input  logic [7:0] usb_data_out,
    input  logic       usb_ep2_empty,
    input  logic       usb_ep4_empty,
    input  logic       usb_ep6_full,
    input  logic       usb_ep8_full,
    output logic [7:0] ep2_data,
    output logic [7:0] ep4_data,
    output logic       ep2_valid,
    output logic       ep4_valid,
    input  logic       ep2_ready,
    input  logic       ep4_ready,
    input  logic [7:0] ep6_data,
    input  logic [7:0] ep8_data,
    input  logic       ep6_valid,
    input  logic       ep8_valid,
    output logic       ep6_read,
    output logic       ep8_read,
    output logic [1:0] grant,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STROBE, RD_WAIT, WR_SETUP, WR_STROBE, WR_WAIT, TURN
    } state_t;

    localparam logic [BURST_W:0] MAX_B = (BURST_W + 1)'(MAX_BURST);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         rr_q, rr_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic [3:0]         elig;
    logic               found;
    logic [1:0]         pick;
    logic [1:0]         idx;
    logic [BURST_W:0]   count_inc;
    logic               more;

    // Handshakes: a read sink with ready high accepts the byte pulsed on epN_valid
    // unconditionally; a write source shows its head byte while valid and pops on epN_read.
    always_comb begin
        elig[0] = !usb_ep2_empty && ep2_ready;
        elig[1] = !usb_ep4_empty && ep4_ready;
        elig[2] = !usb_ep6_full  && ep6_valid;
        elig[3] = !usb_ep8_full  && ep8_valid;
        found = 1'b0;
        pick  = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        count_inc = {1'b0, count_q} + {{BURST_W{1'b0}}, 1'b1};
        more      = elig[grant_q] && (count_inc < MAX_B);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        wr_data_d   = wr_data_q;
        usb_slrd    = 1'b0;
        usb_slwr    = 1'b0;
        usb_sloe    = 1'b0;
        usb_data_oe = 1'b0;
        ep2_valid   = 1'b0;
        ep4_valid   = 1'b0;
        ep6_read    = 1'b0;
        ep8_read    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = pick + 2'd1;
                    state_d = pick[1] ? WR_SETUP : RD_SETUP;
                end
            end
            RD_SETUP: begin
                usb_sloe = 1'b1;
                state_d  = RD_STROBE;
            end
            RD_STROBE: begin
                usb_sloe  = 1'b1;
                usb_slrd  = 1'b1;
                rd_data_d = usb_data_out;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                // FX2 flags have had a cycle to settle since the strobe; sample them here.
                usb_sloe  = 1'b1;
                ep2_valid = !grant_q[0];
                ep4_valid = grant_q[0];
                count_d   = count_inc[BURST_W-1:0];
                state_d   = more ? RD_STROBE : TURN;
            end
            WR_SETUP: begin
                usb_data_oe = 1'b1;
                ep6_read    = !grant_q[0];
                ep8_read    = grant_q[0];
                wr_data_d   = grant_q[0] ? ep8_data : ep6_data;
                state_d     = WR_STROBE;
            end
            WR_STROBE: begin
                usb_data_oe = 1'b1;
                usb_slwr    = 1'b1;
                state_d     = WR_WAIT;
            end
            WR_WAIT: begin
                usb_data_oe = 1'b1;
                count_d     = count_inc[BURST_W-1:0];
                state_d     = more ? WR_SETUP : TURN;
            end
            TURN: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            rr_q      <= 2'd0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign usb_addr    = grant_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign usb_data_in = wr_data_q;
    assign ep2_data    = rd_data_q;
    assign ep4_data    = rd_data_q;
endmodule
